xgmii_40g_tx_framer: RTL and testbench

Upstream neighbour of the 40G PCS transmit path. It accepts 256-bit frame beats from the MAC client over a valid/ready stream and builds the per-lane 40G XGMII column the PCS encoder consumes: start, data, terminate, idle and error lanes with per-lane byte enables. It enforces block-aligned start, terminate placement, minimum inter-packet gap and underrun abort. It also stalls whenever the PCS deasserts its ready, which happens when the gearbox is full.

---
 rtl/xgmii_40g_tx_framer.sv | 207 ++++++++++++++++++++
 tb/tb_xgmii_40g_tx_framer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_40g_tx_framer.sv
// Purpose : turns 256-bit MAC client beats into 4-lane 40G XGMII columns with
//           start / data / terminate / idle / error lane typing, IPG
//           enforcement and underrun abort.
// Latency : 1 cycle from beat acceptance to the column on the outputs.
// Backpressure: everything (state, outputs, counters) holds while pcs_ready_i=0;
//           s_ready_o is also low in TERM_PEND and IPG.
// Ports   : clk/nreset; client stream s_valid_i/s_ready_o/s_data_i/s_keep_i/
//           s_last_i; pcs_ready_i; registered column ctrl_v_o, idle_v_o,
//           start_v_o, term_v_o, err_v_o, data_o, keep_o.
// Option  : XGMII_TX_STATS_EN adds frame_cnt_o / abort_cnt_o (16-bit, saturating).
module xgmii_40g_tx_framer #(
   parameter int LANE_N    = 4,
   parameter int DATA_W    = 64,
   parameter int KEEP_W    = DATA_W/8,
   parameter int IPG_BYTES = 12
) (
   input  logic                       clk,
   input  logic                       nreset,
   input  logic                       s_valid_i,
   output logic                       s_ready_o,
   input  logic [LANE_N*DATA_W-1:0]   s_data_i,
   input  logic [LANE_N*KEEP_W-1:0]   s_keep_i,
   input  logic                       s_last_i,
   input  logic                       pcs_ready_i,
   output logic [LANE_N-1:0]          ctrl_v_o,
   output logic [LANE_N-1:0]          idle_v_o,
   output logic [LANE_N-1:0]          start_v_o,
   output logic [LANE_N-1:0]          term_v_o,
   output logic [LANE_N-1:0]          err_v_o,
   output logic [LANE_N*DATA_W-1:0]   data_o,
   output logic [LANE_N*KEEP_W-1:0]   keep_o
`ifdef XGMII_TX_STATS_EN
   ,
   output logic [15:0]                frame_cnt_o,
   output logic [15:0]                abort_cnt_o
`endif
);

   localparam int BEAT_BYTES = LANE_N*KEEP_W;
   localparam int CNT_W      = $clog2(BEAT_BYTES+1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_DATA      = 3'd1;
   localparam logic [2:0] ST_TERM_PEND = 3'd2;
   localparam logic [2:0] ST_IPG       = 3'd3;
   localparam logic [2:0] ST_ABORT     = 3'd4;

   logic [2:0]                 r_state;
   logic [LANE_N-1:0]          r_ctrl, r_idle, r_start, r_term, r_err;
   logic [LANE_N*DATA_W-1:0]   r_data;
   logic [LANE_N*KEEP_W-1:0]   r_keep;

   logic [2:0]                 w_state_nxt;
   logic [LANE_N-1:0]          w_ctrl_nxt, w_idle_nxt, w_start_nxt, w_term_nxt, w_err_nxt;
   logic [LANE_N*DATA_W-1:0]   w_data_nxt;
   logic [LANE_N*KEEP_W-1:0]   w_keep_nxt;
   logic                       w_accept;
   logic                       w_term_evt;
   logic                       w_err_evt;
   logic [CNT_W-1:0]           w_nbytes;
   int                         w_nb;

   // nreset gates ready so no beat is taken while reset is held.
   assign s_ready_o = pcs_ready_i & nreset &
                      ((r_state == ST_IDLE) | (r_state == ST_DATA) | (r_state == ST_ABORT));
   assign w_accept  = s_valid_i & s_ready_o;
   assign w_nbytes  = CNT_W'($countones(s_keep_i));
   assign w_nb      = int'(w_nbytes);

   always_comb begin
      // Default column: all idle.
      w_state_nxt = r_state;
      w_ctrl_nxt  = '1;
      w_idle_nxt  = '1;
      w_start_nxt = '0;
      w_term_nxt  = '0;
      w_err_nxt   = '0;
      w_data_nxt  = '0;
      w_keep_nxt  = '0;
      w_term_evt  = 1'b0;
      w_err_evt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (s_last_i) begin
                  // A one-beat frame cannot carry start and terminate: reject it.
                  w_idle_nxt = '0;
                  w_err_nxt  = '1;
                  w_err_evt  = 1'b1;
               end else begin
                  w_ctrl_nxt     = '0;
                  w_idle_nxt     = '0;
                  w_ctrl_nxt[0]  = 1'b1;
                  w_start_nxt[0] = 1'b1;
                  w_data_nxt     = s_data_i;
                  w_keep_nxt     = '1;
                  w_state_nxt    = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (!s_valid_i) begin
               w_idle_nxt  = '0;
               w_err_nxt   = '1;
               w_err_evt   = 1'b1;
               w_state_nxt = ST_ABORT;
            end else if (!s_last_i || (w_nb == BEAT_BYTES)) begin
               w_ctrl_nxt = '0;
               w_idle_nxt = '0;
               w_data_nxt = s_data_i;
               w_keep_nxt = '1;
               if (s_last_i) begin
                  w_state_nxt = ST_TERM_PEND;
               end
            end else begin
               // Keep is low-justified, so the terminate lane's own keep slice
               // already holds the (nbytes mod KEEP_W) low bits.
               for (int i = 0; i < LANE_N; i++) begin
                  if ((i+1)*KEEP_W <= w_nb) begin
                     w_ctrl_nxt[i] = 1'b0;
                     w_idle_nxt[i] = 1'b0;
                     w_data_nxt[i*DATA_W +: DATA_W] = s_data_i[i*DATA_W +: DATA_W];
                     w_keep_nxt[i*KEEP_W +: KEEP_W] = '1;
                  end else if (i*KEEP_W <= w_nb) begin
                     w_idle_nxt[i] = 1'b0;
                     w_term_nxt[i] = 1'b1;
                     w_data_nxt[i*DATA_W +: DATA_W] = s_data_i[i*DATA_W +: DATA_W];
                     w_keep_nxt[i*KEEP_W +: KEEP_W] = s_keep_i[i*KEEP_W +: KEEP_W];
                  end
               end
               w_term_evt  = 1'b1;
               w_state_nxt = ((BEAT_BYTES - w_nb) < IPG_BYTES) ? ST_IPG : ST_IDLE;
            end
         end
         ST_TERM_PEND: begin
            w_idle_nxt[0] = 1'b0;
            w_term_nxt[0] = 1'b1;
            w_term_evt    = 1'b1;
            w_state_nxt   = ST_IDLE;
         end
         ST_IPG: begin
            w_state_nxt = ST_IDLE;
         end
         ST_ABORT: begin
            if (w_accept && s_last_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= ST_IDLE;
         r_ctrl  <= '1;
         r_idle  <= '1;
         r_start <= '0;
         r_term  <= '0;
         r_err   <= '0;
         r_data  <= '0;
         r_keep  <= '0;
      end else if (pcs_ready_i) begin
         r_state <= w_state_nxt;
         r_ctrl  <= w_ctrl_nxt;
         r_idle  <= w_idle_nxt;
         r_start <= w_start_nxt;
         r_term  <= w_term_nxt;
         r_err   <= w_err_nxt;
         r_data  <= w_data_nxt;
         r_keep  <= w_keep_nxt;
      end
   end

   assign ctrl_v_o  = r_ctrl;
   assign idle_v_o  = r_idle;
   assign start_v_o = r_start;
   assign term_v_o  = r_term;
   assign err_v_o   = r_err;
   assign data_o    = r_data;
   assign keep_o    = r_keep;

`ifdef XGMII_TX_STATS_EN
   logic [15:0] r_frame_cnt;
   logic [15:0] r_abort_cnt;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_frame_cnt <= '0;
         r_abort_cnt <= '0;
      end else if (pcs_ready_i) begin
         if (w_term_evt && (r_frame_cnt != 16'hFFFF)) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_err_evt && (r_abort_cnt != 16'hFFFF)) begin
            r_abort_cnt <= r_abort_cnt + 16'd1;
         end
      end
   end

   assign frame_cnt_o = r_frame_cnt;
   assign abort_cnt_o = r_abort_cnt;
`endif

endmodule

// File: tb/tb_xgmii_40g_tx_framer.sv
// Purpose : self-checking bench for xgmii_40g_tx_framer (default parameters).
// Latency : expected columns are queued when a beat is driven and popped one
//           cycle later; s_ready_o is checked in the same cycle.
// Backpressure: stall rows expect the previously loaded column to hold.
module tb_xgmii_40g_tx_framer;

   typedef struct packed {
      logic [3:0]   ctrl;
      logic [3:0]   idle;
      logic [3:0]   start;
      logic [3:0]   term;
      logic [3:0]   err;
      logic [255:0] data;
      logic [31:0]  keep;
   } col_t;

   typedef struct {
      bit          vld;
      bit          last;
      logic [31:0] keep;
      int          did;
      bit          prdy;
      bit          erdy;
      col_t        exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         nreset = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [255:0] s_data = '0;
   logic [31:0]  s_keep = '0;
   logic         s_last = 1'b0;
   logic         pcs_ready = 1'b1;
   logic [3:0]   ctrl_v, idle_v, start_v, term_v, err_v;
   logic [255:0] data;
   logic [31:0]  keep;
`ifdef XGMII_TX_STATS_EN
   logic [15:0]  frame_cnt, abort_cnt;
`endif

   int checks = 0;
   int failures = 0;

   vec_t vecs[$];
   col_t sb[$];

   always #5 clk = ~clk;

   xgmii_40g_tx_framer dut (
      .clk         (clk),
      .nreset      (nreset),
      .s_valid_i   (s_valid),
      .s_ready_o   (s_ready),
      .s_data_i    (s_data),
      .s_keep_i    (s_keep),
      .s_last_i    (s_last),
      .pcs_ready_i (pcs_ready),
      .ctrl_v_o    (ctrl_v),
      .idle_v_o    (idle_v),
      .start_v_o   (start_v),
      .term_v_o    (term_v),
      .err_v_o     (err_v),
      .data_o      (data),
      .keep_o      (keep)
`ifdef XGMII_TX_STATS_EN
      ,
      .frame_cnt_o (frame_cnt),
      .abort_cnt_o (abort_cnt)
`endif
   );

   function automatic logic [255:0] dat(input int k);
      logic [255:0] r;
      for (int w = 0; w < 8; w++) r[w*32 +: 32] = (32'(k) << 16) | 32'(w);
      return r;
   endfunction

   function automatic col_t col_idle();
      col_t c = '0;
      c.ctrl = 4'hF;
      c.idle = 4'hF;
      return c;
   endfunction

   function automatic col_t col_err();
      col_t c = '0;
      c.ctrl = 4'hF;
      c.err  = 4'hF;
      return c;
   endfunction

   function automatic col_t col_data(input logic [255:0] d);
      col_t c = '0;
      c.data = d;
      c.keep = 32'hFFFF_FFFF;
      return c;
   endfunction

   function automatic col_t col_start(input logic [255:0] d);
      col_t c = col_data(d);
      c.ctrl[0]  = 1'b1;
      c.start[0] = 1'b1;
      return c;
   endfunction

   // Lanes below 'lane' carry data, 'lane' is terminate with keep kb, rest idle.
   function automatic col_t col_term(input logic [255:0] d, input int lane, input logic [7:0] kb);
      col_t c = '0;
      for (int i = 0; i < 4; i++) begin
         if (i < lane) begin
            c.data[i*64 +: 64] = d[i*64 +: 64];
            c.keep[i*8 +: 8]   = 8'hFF;
         end else if (i == lane) begin
            c.ctrl[i]          = 1'b1;
            c.term[i]          = 1'b1;
            c.data[i*64 +: 64] = d[i*64 +: 64];
            c.keep[i*8 +: 8]   = kb;
         end else begin
            c.ctrl[i] = 1'b1;
            c.idle[i] = 1'b1;
         end
      end
      return c;
   endfunction

   task automatic addv(input bit vld, input bit last, input logic [31:0] kp, input int did,
                       input bit prdy, input bit erdy, input col_t exp);
      vec_t v;
      v.vld = vld; v.last = last; v.keep = kp; v.did = did;
      v.prdy = prdy; v.erdy = erdy; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic check_col(input string name, input col_t exp);
      col_t act;
      act = {ctrl_v, idle_v, start_v, term_v, err_v, data, keep};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got ctrl=%h idle=%h start=%h term=%h err=%h keep=%h data=%h ; want ctrl=%h idle=%h start=%h term=%h err=%h keep=%h data=%h",
                  name, act.ctrl, act.idle, act.start, act.term, act.err, act.keep, act.data,
                  exp.ctrl, exp.idle, exp.start, exp.term, exp.err, exp.keep, exp.data);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

`ifdef XGMII_TX_STATS_EN
   task automatic check_cnt(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask
`endif

   initial begin
      logic [31:0] ones = 32'hFFFF_FFFF;
      col_t c;

      // After reset: idle columns, ready.
      addv(0, 0, ones, 0, 1, 1, col_idle());
      addv(0, 0, ones, 0, 1, 1, col_idle());
      // 3-beat frame, 12 bytes in last beat: gap 20, next start immediately.
      addv(1, 0, ones, 1, 1, 1, col_start(dat(1)));
      addv(1, 0, ones, 2, 1, 1, col_data(dat(2)));
      addv(1, 1, 32'h0000_0FFF, 3, 1, 1, col_term(dat(3), 1, 8'h0F));
      addv(1, 0, ones, 4, 1, 1, col_start(dat(4)));
      // Full last beat: all data, then a lone terminate column.
      addv(1, 0, ones, 5, 1, 1, col_data(dat(5)));
      addv(1, 1, ones, 6, 1, 1, col_data(dat(6)));
      addv(1, 0, ones, 7, 1, 0, col_term('0, 0, 8'h00));
      addv(1, 0, ones, 7, 1, 1, col_start(dat(7)));
      // 28-byte last beat: gap 4, one idle column despite valid held high.
      addv(1, 1, 32'h0FFF_FFFF, 8, 1, 1, col_term(dat(8), 3, 8'h0F));
      addv(1, 0, ones, 9, 1, 0, col_idle());
      addv(1, 0, ones, 9, 1, 1, col_start(dat(9)));
      // PCS stall mid-frame: column held, beat retried, no underrun on valid low.
      addv(1, 0, ones, 10, 0, 0, col_start(dat(9)));
      addv(1, 0, ones, 10, 1, 1, col_data(dat(10)));
      addv(0, 0, ones, 11, 0, 0, col_data(dat(10)));
      // 8-byte last beat: terminate on lane 1 with keep 0.
      addv(1, 1, 32'h0000_00FF, 11, 1, 1, col_term(dat(11), 1, 8'h00));
      addv(0, 0, ones, 0, 1, 1, col_idle());
      // Underrun: error column, then beats discarded through last.
      addv(1, 0, ones, 12, 1, 1, col_start(dat(12)));
      addv(0, 0, ones, 0, 1, 1, col_err());
      addv(1, 0, ones, 13, 1, 1, col_idle());
      addv(1, 1, 32'h0000_000F, 14, 1, 1, col_idle());
      // 1-byte last beat: terminate on lane 0.
      addv(1, 0, ones, 15, 1, 1, col_start(dat(15)));
      addv(1, 1, 32'h0000_0001, 16, 1, 1, col_term(dat(16), 0, 8'h01));
      // Last flag on a first beat is illegal: error column, stay idle.
      addv(1, 1, ones, 17, 1, 1, col_err());
      addv(0, 0, ones, 0, 1, 1, col_idle());

      // Reset state with PCS ready and no beats.
      pcs_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_col("reset_col", col_idle());
      check_bit("reset_rdy", s_ready, 1'b0);
      nreset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         if (sb.size() > 0) begin
            c = sb.pop_front();
            check_col($sformatf("col%0d", i-1), c);
         end
         s_valid   = vecs[i].vld;
         s_last    = vecs[i].last;
         s_keep    = vecs[i].keep;
         s_data    = dat(vecs[i].did);
         pcs_ready = vecs[i].prdy;
         #1;
         check_bit($sformatf("rdy%0d", i), s_ready, vecs[i].erdy);
         sb.push_back(vecs[i].exp);
      end
      @(negedge clk);
      while (sb.size() > 0) begin
         c = sb.pop_front();
         check_col("col_last", c);
      end
`ifdef XGMII_TX_STATS_EN
      check_cnt("frame_cnt", frame_cnt, 16'd5);
      check_cnt("abort_cnt", abort_cnt, 16'd2);
`endif

      // Reset mid-frame: frame dropped, no terminate or error afterwards.
      s_valid = 1'b1; s_last = 1'b0; s_keep = ones; s_data = dat(20); pcs_ready = 1'b1;
      @(negedge clk);
      check_col("mid_start", col_start(dat(20)));
      s_data = dat(21);
      #2 nreset = 1'b0;
      #1;
      check_col("mid_rst_col", col_idle());
      check_bit("mid_rst_rdy", s_ready, 1'b0);
      @(negedge clk);
      s_valid = 1'b0;
      nreset = 1'b1;
      @(negedge clk);
      check_col("post_rst_col", col_idle());
      check_bit("post_rst_rdy", s_ready, 1'b1);
`ifdef XGMII_TX_STATS_EN
      check_cnt("frame_cnt_rst", frame_cnt, 16'd0);
      check_cnt("abort_cnt_rst", abort_cnt, 16'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
